// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the 2-wide fetch stage:
//   - Alpha opcode constants used by predecode (BR, BSR, conditional range)
//   - fetch_slot_t: one slot of the IF/ID pipeline register
//   - opcode classification helpers
// -----------------------------------------------------------------------------
package if_stage_pkg;

    localparam int OPCODE_W = 6;

    // Unconditional PC-relative branches.
    localparam logic [OPCODE_W-1:0] OP_BR      = 6'h30;
    localparam logic [OPCODE_W-1:0] OP_BSR     = 6'h34;
    // Integer conditional branches occupy 0x38..0x3F.
    localparam logic [OPCODE_W-1:0] OP_COND_LO = 6'h38;

    // Storage width of the BHR snapshot inside a slot. The top-level BHR
    // width parameter must not exceed this; unused upper bits stay zero.
    localparam int BHR_FIELD_W = 16;

    typedef struct packed {
        logic [31:0]            inst;
        logic [63:0]            npc;
        logic                   valid;
        logic                   pred_taken;
        logic [63:0]            pred_target;
        logic [BHR_FIELD_W-1:0] bhr;
    } fetch_slot_t;

    function automatic logic is_cond_op(input logic [OPCODE_W-1:0] op);
        return (op >= OP_COND_LO);
    endfunction

    function automatic logic is_uncond_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_BR) || (op == OP_BSR);
    endfunction

endpackage

// File: rtl/if_stage_predecode.sv
// -----------------------------------------------------------------------------
// if_stage_predecode
// Predecodes one 32-bit Alpha instruction slot.
// Ports:
//   slot_pc   in  64  address of this slot
//   inst      in  32  instruction word
//   npc       out 64  slot_pc + 4
//   is_cond   out 1   integer conditional branch (opcode 0x38..0x3F)
//   is_uncond out 1   BR or BSR
//   target    out 64  npc + sext(disp21) << 2
// -----------------------------------------------------------------------------
module if_stage_predecode
    import if_stage_pkg::*;
(
    input  logic [63:0] slot_pc,
    input  logic [31:0] inst,
    output logic [63:0] npc,
    output logic        is_cond,
    output logic        is_uncond,
    output logic [63:0] target
);

    logic [OPCODE_W-1:0] opcode;
    logic [63:0]         disp_ext;
    logic                unused_ra;

    assign opcode    = inst[31:26];
    assign npc       = slot_pc + 64'd4;
    assign is_cond   = is_cond_op(opcode);
    assign is_uncond = is_uncond_op(opcode);

    // Branch displacement is a signed longword count.
    assign disp_ext  = {{41{inst[20]}}, inst[20:0], 2'b00};
    assign target    = npc + disp_ext;

    // Register field is irrelevant to fetch.
    assign unused_ra = ^inst[25:21];

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// 2-wide instruction fetch plus IF/ID pipeline register.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   Imem2proc_data / Imem_valid  fetched doubleword (slot0 = [31:0]) and valid
//   proc2Imem_addr               aligned fetch address {PC[63:3],3'b0}
//   recover / recover_pc         redirect from the ROB (highest after reset)
//   id_stall                     ID cannot accept; hold PC and IF/ID
//   if_NPC0/1, if_valid_cond0/1  BHT query (index PC+4, conditional strobes)
//   bht_taken0/1, bht_bhr0/1     same-cycle BHT answer
//   id_*                         registered fetch group for ID
// -----------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter int          BIT_BHT  = 6,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [63:0]        Imem2proc_data,
    input  logic               Imem_valid,
    output logic [63:0]        proc2Imem_addr,
    input  logic               recover,
    input  logic [63:0]        recover_pc,
    input  logic               id_stall,
    output logic [63:0]        if_NPC0,
    output logic [63:0]        if_NPC1,
    output logic               if_valid_cond0,
    output logic               if_valid_cond1,
    input  logic               bht_taken0,
    input  logic               bht_taken1,
    input  logic [BIT_BHT-1:0] bht_bhr0,
    input  logic [BIT_BHT-1:0] bht_bhr1,
    output logic [31:0]        id_inst0,
    output logic [31:0]        id_inst1,
    output logic [63:0]        id_NPC0,
    output logic [63:0]        id_NPC1,
    output logic               id_valid0,
    output logic               id_valid1,
    output logic               id_pred_taken0,
    output logic               id_pred_taken1,
    output logic [63:0]        id_pred_target0,
    output logic [63:0]        id_pred_target1,
    output logic [BIT_BHT-1:0] id_bhr0,
    output logic [BIT_BHT-1:0] id_bhr1
);

    logic [63:0]        pc_q, pc_d;
    fetch_slot_t        id_q [2];
    fetch_slot_t        id_d [2];
    fetch_slot_t        new_slot [2];

    logic [63:0]        slot_pc     [2];
    logic [31:0]        slot_inst   [2];
    logic [63:0]        slot_npc    [2];
    logic [63:0]        slot_target [2];
    logic               slot_cond   [2];
    logic               slot_uncond [2];
    logic               slot_bht    [2];
    logic [BIT_BHT-1:0] slot_bhr    [2];
    logic               taken_eff   [2];
    logic               live        [2];

    logic               fetch_ok;
    logic               redirect0;
    logic               unused_pc_lo;

    // ---------------------------------------------------------------- slots
    assign slot_pc[0]   = {pc_q[63:3], 3'b000};
    assign slot_pc[1]   = {pc_q[63:3], 3'b100};
    assign slot_inst[0] = Imem2proc_data[31:0];
    assign slot_inst[1] = Imem2proc_data[63:32];
    assign slot_bht[0]  = bht_taken0;
    assign slot_bht[1]  = bht_taken1;
    assign slot_bhr[0]  = bht_bhr0;
    assign slot_bhr[1]  = bht_bhr1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            if_stage_predecode u_predecode (
                .slot_pc   (slot_pc[gi]),
                .inst      (slot_inst[gi]),
                .npc       (slot_npc[gi]),
                .is_cond   (slot_cond[gi]),
                .is_uncond (slot_uncond[gi]),
                .target    (slot_target[gi])
            );
            assign taken_eff[gi] = slot_uncond[gi] | (slot_cond[gi] & slot_bht[gi]);
        end
    endgenerate

    // A slot is only live when the group will actually be accepted this
    // cycle; this also keeps the BHT strobes quiet during stalls/redirects.
    assign fetch_ok  = Imem_valid & ~recover & ~id_stall & ~reset;
    assign live[0]   = fetch_ok & ~pc_q[2];
    assign live[1]   = fetch_ok;
    assign redirect0 = live[0] & taken_eff[0];

    // ------------------------------------------------------------ BHT query
    assign if_NPC0        = slot_npc[0];
    assign if_NPC1        = slot_npc[1];
    assign if_valid_cond0 = live[0] & slot_cond[0];
    // Slot1 is dead behind a taken slot0; strobing it would shift the BHR.
    assign if_valid_cond1 = live[1] & slot_cond[1] & ~redirect0;

    assign proc2Imem_addr = {pc_q[63:3], 3'b000};
    assign unused_pc_lo   = ^pc_q[1:0];

    // -------------------------------------------------------------- next PC
    always_comb begin
        pc_d = pc_q;
        if (recover) begin
            pc_d = recover_pc;
        end else if (fetch_ok) begin
            if (redirect0) begin
                pc_d = slot_target[0];
            end else if (live[1] & taken_eff[1]) begin
                pc_d = slot_target[1];
            end else begin
                pc_d = {pc_q[63:3] + 61'd1, 3'b000};
            end
        end
    end

    // ---------------------------------------------------- new IF/ID contents
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            new_slot[i]                      = '0;
            new_slot[i].inst                 = slot_inst[i];
            new_slot[i].npc                  = slot_npc[i];
            new_slot[i].pred_target          = slot_target[i];
            new_slot[i].bhr[BIT_BHT-1:0]     = slot_bhr[i];
        end
        new_slot[0].valid      = live[0];
        new_slot[0].pred_taken = redirect0;
        new_slot[1].valid      = live[1] & ~redirect0;
        new_slot[1].pred_taken = live[1] & ~redirect0 & taken_eff[1];
    end

    always_comb begin
        id_d[0] = id_q[0];
        id_d[1] = id_q[1];
        if (recover) begin
            id_d[0].valid = 1'b0;
            id_d[1].valid = 1'b0;
        end else if (!id_stall) begin
            if (Imem_valid) begin
                id_d[0] = new_slot[0];
                id_d[1] = new_slot[1];
            end else begin
                // Bubble: payload is don't-care once valid drops.
                id_d[0].valid = 1'b0;
                id_d[1].valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            id_q[0] <= '0;
            id_q[1] <= '0;
        end else begin
            pc_q    <= pc_d;
            id_q[0] <= id_d[0];
            id_q[1] <= id_d[1];
        end
    end

    // --------------------------------------------------------------- to ID
    assign id_inst0        = id_q[0].inst;
    assign id_inst1        = id_q[1].inst;
    assign id_NPC0         = id_q[0].npc;
    assign id_NPC1         = id_q[1].npc;
    assign id_valid0       = id_q[0].valid;
    assign id_valid1       = id_q[1].valid;
    assign id_pred_taken0  = id_q[0].pred_taken;
    assign id_pred_taken1  = id_q[1].pred_taken;
    assign id_pred_target0 = id_q[0].pred_target;
    assign id_pred_target1 = id_q[1].pred_target;
    assign id_bhr0         = id_q[0].bhr[BIT_BHT-1:0];
    assign id_bhr1         = id_q[1].bhr[BIT_BHT-1:0];

    generate
        if (BIT_BHT < BHR_FIELD_W) begin : g_bhr_pad
            logic unused_bhr_hi;
            assign unused_bhr_hi = ^{id_q[0].bhr[BHR_FIELD_W-1:BIT_BHT],
                                     id_q[1].bhr[BHR_FIELD_W-1:BIT_BHT]};
        end
    endgenerate

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed vectors with hand-computed results. The driver applies one vector
// per cycle, checks the combinational fetch/BHT outputs, and queues the
// expected IF/ID contents; a monitor pops and compares after each edge.
// -----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] ALU0  = 32'h4021_0401;
    localparam logic [31:0] ALU1  = 32'h4442_0402;
    localparam logic [31:0] BEQ4  = 32'hE400_0004; // BEQ disp +4
    localparam logic [31:0] BNE8  = 32'hF400_0008; // BNE disp +8
    localparam logic [31:0] BR3   = 32'hC000_0003; // BR  disp +3
    localparam logic [31:0] BSRM2 = 32'hD01F_FFFE; // BSR disp -2

    logic        clock;
    logic        reset;
    logic [63:0] Imem2proc_data;
    logic        Imem_valid;
    logic [63:0] proc2Imem_addr;
    logic        recover;
    logic [63:0] recover_pc;
    logic        id_stall;
    logic [63:0] if_NPC0, if_NPC1;
    logic        if_valid_cond0, if_valid_cond1;
    logic        bht_taken0, bht_taken1;
    logic [5:0]  bht_bhr0, bht_bhr1;
    logic [31:0] id_inst0, id_inst1;
    logic [63:0] id_NPC0, id_NPC1;
    logic        id_valid0, id_valid1;
    logic        id_pred_taken0, id_pred_taken1;
    logic [63:0] id_pred_target0, id_pred_target1;
    logic [5:0]  id_bhr0, id_bhr1;

    if_stage #(.BIT_BHT(6), .RESET_PC(64'h0)) dut (
        .clock(clock), .reset(reset),
        .Imem2proc_data(Imem2proc_data), .Imem_valid(Imem_valid),
        .proc2Imem_addr(proc2Imem_addr),
        .recover(recover), .recover_pc(recover_pc), .id_stall(id_stall),
        .if_NPC0(if_NPC0), .if_NPC1(if_NPC1),
        .if_valid_cond0(if_valid_cond0), .if_valid_cond1(if_valid_cond1),
        .bht_taken0(bht_taken0), .bht_taken1(bht_taken1),
        .bht_bhr0(bht_bhr0), .bht_bhr1(bht_bhr1),
        .id_inst0(id_inst0), .id_inst1(id_inst1),
        .id_NPC0(id_NPC0), .id_NPC1(id_NPC1),
        .id_valid0(id_valid0), .id_valid1(id_valid1),
        .id_pred_taken0(id_pred_taken0), .id_pred_taken1(id_pred_taken1),
        .id_pred_target0(id_pred_target0), .id_pred_target1(id_pred_target1),
        .id_bhr0(id_bhr0), .id_bhr1(id_bhr1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int          idx;
        logic        v0, v1;
        logic [63:0] n0, n1;
        logic        p0, p1;
        logic [63:0] g0, g1;
        logic [31:0] i0, i1;
        logic [5:0]  b0, b1;
    } exp_t;

    typedef struct {
        logic        iv;
        logic [31:0] d0, d1;
        logic        rec;
        logic [63:0] rpc;
        logic        st;
        logic        t0, t1;
        logic [5:0]  b0, b1;
        logic [63:0] addr;
        logic        c0, c1;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic vec_t mkv(
        input logic iv, input logic [31:0] d0, input logic [31:0] d1,
        input logic rec, input logic [63:0] rpc, input logic st,
        input logic t0, input logic t1, input logic [5:0] b0, input logic [5:0] b1,
        input logic [63:0] addr, input logic c0, input logic c1,
        input logic v0, input logic v1, input logic [63:0] n0, input logic [63:0] n1,
        input logic p0, input logic p1, input logic [63:0] g0, input logic [63:0] g1,
        input logic [31:0] i0, input logic [31:0] i1, input logic [5:0] eb0, input logic [5:0] eb1);
        vec_t v;
        v.iv = iv; v.d0 = d0; v.d1 = d1; v.rec = rec; v.rpc = rpc; v.st = st;
        v.t0 = t0; v.t1 = t1; v.b0 = b0; v.b1 = b1;
        v.addr = addr; v.c0 = c0; v.c1 = c1;
        v.e.idx = 0;
        v.e.v0 = v0; v.e.v1 = v1; v.e.n0 = n0; v.e.n1 = n1;
        v.e.p0 = p0; v.e.p1 = p1; v.e.g0 = g0; v.e.g1 = g1;
        v.e.i0 = i0; v.e.i1 = i1; v.e.b0 = eb0; v.e.b1 = eb1;
        return v;
    endfunction

    // Monitor: one IF/ID transaction per edge that has an expectation queued.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("t%0d id_valid0", e.idx), 64'(id_valid0), 64'(e.v0));
                check($sformatf("t%0d id_valid1", e.idx), 64'(id_valid1), 64'(e.v1));
                if (e.v0) begin
                    check($sformatf("t%0d id_NPC0", e.idx), id_NPC0, e.n0);
                    check($sformatf("t%0d id_inst0", e.idx), 64'(id_inst0), 64'(e.i0));
                    check($sformatf("t%0d id_pred_taken0", e.idx), 64'(id_pred_taken0), 64'(e.p0));
                    check($sformatf("t%0d id_bhr0", e.idx), 64'(id_bhr0), 64'(e.b0));
                    if (e.p0) check($sformatf("t%0d id_pred_target0", e.idx), id_pred_target0, e.g0);
                end
                if (e.v1) begin
                    check($sformatf("t%0d id_NPC1", e.idx), id_NPC1, e.n1);
                    check($sformatf("t%0d id_inst1", e.idx), 64'(id_inst1), 64'(e.i1));
                    check($sformatf("t%0d id_pred_taken1", e.idx), 64'(id_pred_taken1), 64'(e.p1));
                    check($sformatf("t%0d id_bhr1", e.idx), 64'(id_bhr1), 64'(e.b1));
                    if (e.p1) check($sformatf("t%0d id_pred_target1", e.idx), id_pred_target1, e.g1);
                end
                $display("txn %0d: id_valid=%b%b NPC0=%h NPC1=%h taken=%b%b", e.idx,
                         id_valid0, id_valid1, id_NPC0, id_NPC1, id_pred_taken0, id_pred_taken1);
            end
        end
    end

    // Driver
    initial begin
        // iv d0 d1 rec rpc st t0 t1 b0 b1 | addr c0 c1 | v0 v1 n0 n1 p0 p1 g0 g1 i0 i1 eb0 eb1
        // 0: redirect to 0x100
        vecs.push_back(mkv(0, ALU0, ALU1, 1, 64'h100, 0, 0, 0, 6'h00, 6'h00, 64'h0, 0, 0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 1: two ALU ops at 0x100
        vecs.push_back(mkv(1, ALU0, ALU1, 0, 0, 0, 0, 0, 6'h01, 6'h02, 64'h100, 0, 0,
                           1, 1, 64'h104, 64'h108, 0, 0, 0, 0, ALU0, ALU1, 6'h01, 6'h02));
        // 2: redirect to 0x200 while a group is offered
        vecs.push_back(mkv(1, ALU0, ALU1, 1, 64'h200, 0, 0, 0, 6'h01, 6'h02, 64'h108, 0, 0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 3: slot0 BEQ taken kills slot1 BNE
        vecs.push_back(mkv(1, BEQ4, BNE8, 0, 0, 0, 1, 1, 6'h15, 6'h16, 64'h200, 1, 0,
                           1, 0, 64'h204, 0, 1, 0, 64'h214, 0, BEQ4, 0, 6'h15, 0));
        // 4: misaligned PC 0x214 -> slot1 only
        vecs.push_back(mkv(1, BEQ4, ALU1, 0, 0, 0, 1, 0, 6'h09, 6'h0A, 64'h210, 0, 0,
                           0, 1, 0, 64'h218, 0, 0, 0, 0, 0, ALU1, 0, 6'h0A));
        // 5: slot0 BR, slot1 BNE -> no strobes, slot1 killed
        vecs.push_back(mkv(1, BR3, BNE8, 0, 0, 0, 0, 1, 6'h03, 6'h04, 64'h218, 0, 0,
                           1, 0, 64'h21C, 0, 1, 0, 64'h228, 0, BR3, 0, 6'h03, 0));
        // 6: slot1 BNE predicted taken
        vecs.push_back(mkv(1, ALU0, BNE8, 0, 0, 0, 0, 1, 6'h05, 6'h2A, 64'h228, 0, 1,
                           1, 1, 64'h22C, 64'h230, 0, 1, 0, 64'h250, ALU0, BNE8, 6'h05, 6'h2A));
        // 7: slot0 BEQ not taken -> fall through
        vecs.push_back(mkv(1, BEQ4, ALU1, 0, 0, 0, 0, 0, 6'h11, 6'h12, 64'h250, 1, 0,
                           1, 1, 64'h254, 64'h258, 0, 0, 0, 0, BEQ4, ALU1, 6'h11, 6'h12));
        // 8: stall holds IF/ID and PC
        vecs.push_back(mkv(1, BEQ4, BNE8, 0, 0, 1, 1, 1, 6'h21, 6'h22, 64'h258, 0, 0,
                           1, 1, 64'h254, 64'h258, 0, 0, 0, 0, BEQ4, ALU1, 6'h11, 6'h12));
        // 9: recover overrides stall
        vecs.push_back(mkv(1, BEQ4, BNE8, 1, 64'h400, 1, 1, 1, 6'h21, 6'h22, 64'h258, 0, 0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 10-12: no I-mem data for three cycles
        for (int k = 0; k < 3; k++)
            vecs.push_back(mkv(0, BEQ4, BNE8, 0, 0, 0, 1, 1, 6'h00, 6'h00, 64'h400, 0, 0,
                               0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // 13: resume at 0x400
        vecs.push_back(mkv(1, ALU0, ALU1, 0, 0, 0, 0, 0, 6'h01, 6'h02, 64'h400, 0, 0,
                           1, 1, 64'h404, 64'h408, 0, 0, 0, 0, ALU0, ALU1, 6'h01, 6'h02));
        // 14: slot1 BSR with negative displacement
        vecs.push_back(mkv(1, ALU0, BSRM2, 0, 0, 0, 0, 0, 6'h07, 6'h08, 64'h408, 0, 0,
                           1, 1, 64'h40C, 64'h410, 0, 1, 0, 64'h408, ALU0, BSRM2, 6'h07, 6'h08));
        // 15: BSR loops back to 0x408
        vecs.push_back(mkv(0, ALU0, ALU1, 0, 0, 0, 0, 0, 6'h00, 6'h00, 64'h408, 0, 0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset with a live-looking conditional group on the bus.
        reset          = 1'b1;
        Imem_valid     = 1'b1;
        Imem2proc_data = {BNE8, BEQ4};
        recover        = 1'b0;
        recover_pc     = 64'h0;
        id_stall       = 1'b0;
        bht_taken0     = 1'b1;
        bht_taken1     = 1'b1;
        bht_bhr0       = 6'h3F;
        bht_bhr1       = 6'h3F;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("reset proc2Imem_addr", proc2Imem_addr, 64'h0);
        check("reset id_valid0", 64'(id_valid0), 64'd0);
        check("reset id_valid1", 64'(id_valid1), 64'd0);
        check("reset if_valid_cond0", 64'(if_valid_cond0), 64'd0);
        check("reset if_valid_cond1", 64'(if_valid_cond1), 64'd0);
        $display("txn reset: addr=%h id_valid=%b%b", proc2Imem_addr, id_valid0, id_valid1);

        for (int n = 0; n < vecs.size(); n++) begin
            vec_t v;
            exp_t e;
            v = vecs[n];
            reset          = 1'b0;
            Imem_valid     = v.iv;
            Imem2proc_data = {v.d1, v.d0};
            recover        = v.rec;
            recover_pc     = v.rpc;
            id_stall       = v.st;
            bht_taken0     = v.t0;
            bht_taken1     = v.t1;
            bht_bhr0       = v.b0;
            bht_bhr1       = v.b1;
            #1;
            check($sformatf("t%0d proc2Imem_addr", n), proc2Imem_addr, v.addr);
            check($sformatf("t%0d if_valid_cond0", n), 64'(if_valid_cond0), 64'(v.c0));
            check($sformatf("t%0d if_valid_cond1", n), 64'(if_valid_cond1), 64'(v.c1));
            e     = v.e;
            e.idx = n;
            exp_q.push_back(e);
            @(negedge clock);
        end

        Imem_valid = 1'b0;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending transactions required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
